frame_dispatch: RTL

Ingress-to-egress dispatch stage directly downstream of the frame processor. It consumes the processor's tagged byte stream: `sof`/`dv`/`data`, where header byte 0 is {len[11:8], egress_portmap[3:0]} and byte 1 is len[7:0]. It replicates the frame body into the selected egress queues and commits one pointer word per queue at end of frame. It also drives the per-port backpressure `bp0..bp3` that the frame processor samples.

---
 rtl/frame_dispatch_pkg.sv | 30 +++
 rtl/frame_dispatch_stats.sv | 35 +++
 rtl/frame_dispatch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/frame_dispatch_pkg.sv
// frame_dispatch_pkg: shared encodings for the frame dispatch stage.
// State encoding, default frame limit, header and pointer field positions.
package frame_dispatch_pkg;

  localparam int MAX_LEN_DEF = 1536;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR1 = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // pointer word: {bad, 4'b0, cnt[10:0]}
  localparam int PTR_BAD_BIT = 15;
  localparam int PTR_CNT_MSB = 10;

  // header byte 0: {len[11:8], egress_portmap[3:0]}
  localparam int HDR_MAP_MSB    = 3;
  localparam int HDR_MAP_LSB    = 0;
  localparam int HDR_LEN_HI_MSB = 7;
  localparam int HDR_LEN_HI_LSB = 4;

  function automatic logic [15:0] mk_ptr(input logic bad, input logic [PTR_CNT_MSB:0] cnt);
    logic [15:0] p;
    p = '0;
    p[PTR_BAD_BIT] = bad;
    p[PTR_CNT_MSB:0] = cnt;
    return p;
  endfunction

endpackage

// File: rtl/frame_dispatch_stats.sv
// dispatch_stats: ok/bad/drop frame counters, wrap at 2^32.
// Pulses are re-registered so each count moves one cycle after its event.
module dispatch_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        ok_p,
  input  logic        bad_p,
  input  logic        drop_p,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_bad,
  output logic [31:0] stat_drop
);

  logic ok_q, bad_q, drop_q;

  // delay event pulses one cycle, then accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
      drop_q    <= 1'b0;
      stat_ok   <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
    end else begin
      ok_q      <= ok_p;
      bad_q     <= bad_p;
      drop_q    <= drop_p;
      stat_ok   <= stat_ok   + {31'd0, ok_q};
      stat_bad  <= stat_bad  + {31'd0, bad_q};
      stat_drop <= stat_drop + {31'd0, drop_q};
    end
  end

endmodule

// File: rtl/frame_dispatch.sv
// frame_dispatch: replicates a tagged frame body into selected egress
// queues and commits one pointer per queue at end of frame.
// Optional FRAME_DISPATCH_STATS_EN adds ok/bad/drop frame counters.
module frame_dispatch
  import frame_dispatch_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        dv,
  input  logic [7:0]  data,
  output logic        bp0,
  output logic        bp1,
  output logic        bp2,
  output logic        bp3,
  input  logic [3:0]  q_space_ok,
  output logic [7:0]  q_din,
  output logic [3:0]  q_wr,
  output logic [15:0] q_ptr_din,
  output logic [3:0]  q_ptr_wr
`ifdef FRAME_DISPATCH_STATS_EN
  ,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_bad,
  output logic [31:0] stat_drop
`endif
);

  localparam logic [11:0] MAX_CNT = 12'(MAX_LEN);

  logic [1:0]  state;
  logic [3:0]  mask, len_hi, bp_r;
  logic [11:0] cnt, len;
  logic        bad;
  logic        hdr_load, fin_bad;

  // header byte 0 is accepted from IDLE and also from BODY (back-to-back sof)
  assign hdr_load = sof && dv && (state == S_IDLE || state == S_BODY);
  assign fin_bad  = bad || (cnt != len);

  assign bp0 = bp_r[0];
  assign bp1 = bp_r[1];
  assign bp2 = bp_r[2];
  assign bp3 = bp_r[3];

  // dispatch FSM, egress datapath and backpressure register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mask      <= '0;
      len_hi    <= '0;
      len       <= '0;
      cnt       <= '0;
      bad       <= 1'b0;
      q_din     <= '0;
      q_wr      <= '0;
      q_ptr_din <= '0;
      q_ptr_wr  <= '0;
      bp_r      <= 4'hF;
    end else begin
      q_wr     <= '0;
      q_ptr_wr <= '0;
      bp_r     <= ~q_space_ok;
      // mask frozen here; later q_space_ok changes don't touch this frame
      if (hdr_load) begin
        mask   <= data[HDR_MAP_MSB:HDR_MAP_LSB] & q_space_ok;
        len_hi <= data[HDR_LEN_HI_MSB:HDR_LEN_HI_LSB];
        cnt    <= '0;
        bad    <= 1'b0;
      end
      case (state)
        S_IDLE: if (hdr_load) state <= S_HDR1;
        S_HDR1: begin
          if (dv) begin
            len   <= {len_hi, data};
            state <= (mask == 4'd0) ? S_DROP : S_BODY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BODY: begin
          if (dv && sof) begin
            // cut-off frame is committed bad while the new header is latched
            q_ptr_wr  <= mask;
            q_ptr_din <= mk_ptr(1'b1, cnt[PTR_CNT_MSB:0]);
            state     <= S_HDR1;
          end else if (dv) begin
            q_din <= data;
            if (cnt < MAX_CNT) begin
              q_wr <= mask;
              cnt  <= cnt + 12'd1;
            end else begin
              bad <= 1'b1;
            end
          end else begin
            q_ptr_wr  <= mask;
            q_ptr_din <= mk_ptr(fin_bad, cnt[PTR_CNT_MSB:0]);
            state     <= S_IDLE;
          end
        end
        S_DROP: if (!dv) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_DISPATCH_STATS_EN
  logic ev_ok, ev_bad, ev_drop;

  // one-cycle event strobes aligned with the committing/dropping edge
  always_comb begin
    ev_drop = (state == S_HDR1) && (!dv || mask == 4'd0);
    ev_ok   = (state == S_BODY) && !dv && !fin_bad;
    ev_bad  = (state == S_BODY) && ((dv && sof) || (!dv && fin_bad));
  end

  dispatch_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .ok_p      (ev_ok),
    .bad_p     (ev_bad),
    .drop_p    (ev_drop),
    .stat_ok   (stat_ok),
    .stat_bad  (stat_bad),
    .stat_drop (stat_drop)
  );
`endif

endmodule
